bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the bus arbiter slice.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_TIMEOUT = 255;

  // Width of a counter that must be able to hold the value n.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request found searching
// upward from ptr+1, wrapping modulo N_REQ.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic found;
  int   cand;

  // Walk the N_REQ candidates in priority order; the first hit wins.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    any   = |req;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                   = 1'b1;
        pick[cand[IDX_W-1:0]]   = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Burst bus arbiter: round-robin grant of a shared bus to one of N_REQ
// requesters for a whole burst of len+1 beats, with one idle cycle
// between bursts. Optional stall watchdog enabled by BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int N_REQ   = DEF_N_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int LEN_W   = DEF_LEN_W,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    bus_valid,
  output logic [DATA_W-1:0]       bus_data,
  output logic [IDX_W-1:0]        bus_src,
  output logic                    bus_last,
  input  logic                    bus_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_err
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   sel_q;
  logic [N_REQ-1:0]   grant_q;
  logic               busy_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   beat_cnt;

  logic [N_REQ-1:0]   pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               beat_done;
  logic               stall_hit;
  logic               end_burst;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req  (req_valid),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (any_req)
  );

  // Bus mux: only the granted requester sees bus_ready; all quiet in IDLE.
  always_comb begin
    bus_valid = 1'b0;
    bus_data  = '0;
    req_ready = '0;
    bus_last  = 1'b0;
    if (state_q == XFER) begin
      bus_valid        = req_valid[sel_q];
      bus_data         = req_data[int'(sel_q)*DATA_W +: DATA_W];
      req_ready[sel_q] = bus_ready;
      bus_last         = bus_valid && (beat_cnt == len_q);
    end
  end

  assign beat_done = bus_valid && bus_ready;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int STALL_W = cnt_w(TIMEOUT);

  logic [STALL_W-1:0] stall_cnt;
  logic               timeout_q;

  // A completed beat in the same cycle as the limit wins over the abort.
  assign stall_hit = (state_q == XFER) && !beat_done &&
                     (stall_cnt == STALL_W'(TIMEOUT));

  // Stall counter clears in IDLE (covers grant) and on every beat; saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_hit;
      if (state_q == IDLE || beat_done)
        stall_cnt <= '0;
      else if (stall_cnt != STALL_W'(TIMEOUT))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign end_burst = (state_q == XFER) && ((beat_done && bus_last) || stall_hit);

  // Next-state: grant on any request, return to IDLE after the last beat
  // or a stall abort; IDLE always lasts at least one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = XFER;
      XFER:    if (end_burst) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Burst bookkeeping: latch winner and length at grant, count beats,
  // hand priority past the finished requester at burst end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= IDX_W'(N_REQ - 1);
      sel_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            grant_q  <= pick;
            busy_q   <= 1'b1;
            sel_q    <= pick_idx;
            len_q    <= req_len[int'(pick_idx)*LEN_W +: LEN_W];
            beat_cnt <= '0;
          end
        end
        XFER: begin
          if (end_burst) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q;
          end
          if (beat_done) beat_cnt <= beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign bus_src = sel_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_REQ=4, DATA_W=32, LEN_W=4, TIMEOUT=8).
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            bus_valid;
  logic [DW-1:0]   bus_data;
  logic [1:0]      bus_src;
  logic            bus_last;
  logic            bus_ready;
  logic [N-1:0]    grant;
  logic            busy;
  logic            timeout_err;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(N), .DATA_W(DW), .LEN_W(LW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
    .req_data(req_data), .req_ready(req_ready), .bus_valid(bus_valid),
    .bus_data(bus_data), .bus_src(bus_src), .bus_last(bus_last),
    .bus_ready(bus_ready), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
    req_len[i*LW +: LW] = l;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; bus_ready = 1'b0;
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'hF; bus_ready = 1'b1;
    req_len = '0; req_data = '0;
    cyc; cyc; #1;
    n_tot++; if (grant !== 4'b0) $display("FAIL reset_grant got=%b exp=0000", grant); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_tot++; if (bus_valid !== 1'b0 || req_ready !== 4'b0) $display("FAIL reset_bus got=%b/%b exp=0/0000", bus_valid, req_ready); else n_pass++;
    n_tot++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout got=%b exp=0", timeout_err); else n_pass++;
    n_tot++; if (bus_src !== 2'd0) $display("FAIL reset_src got=%0d exp=0", bus_src); else n_pass++;
    rst = 1'b0; req_valid = '0; bus_ready = 1'b0;
  endtask

  task automatic test_single;
    set_req(0, 4'd3, 32'hA0); req_valid = 4'b0001; bus_ready = 1'b1; #1;
    n_tot++; if (grant !== 4'b0) $display("FAIL single_pregrant got=%b exp=0000", grant); else n_pass++;
    cyc;
    n_tot++; if (grant !== 4'b0001 || busy !== 1'b1) $display("FAIL single_grant got=%b/%b exp=0001/1", grant, busy); else n_pass++;
    for (int b = 0; b < 4; b++) begin
      req_data[DW-1:0] = DW'(32'hA0 + b); #1;
      n_tot++; if (bus_valid !== 1'b1 || bus_data !== DW'(32'hA0 + b) || req_ready !== 4'b0001)
        $display("FAIL single_beat%0d got=%b/%h/%b exp=1/%h/0001", b, bus_valid, bus_data, req_ready, 32'hA0 + b); else n_pass++;
      n_tot++; if (bus_last !== (b == 3)) $display("FAIL single_last%0d got=%b exp=%b", b, bus_last, (b == 3)); else n_pass++;
      cyc;
    end
    req_valid = '0; #1;
    n_tot++; if (busy !== 1'b0 || grant !== 4'b0 || bus_valid !== 1'b0) $display("FAIL single_done got=%b/%b/%b exp=0/0000/0", busy, grant, bus_valid); else n_pass++;
    n_tot++; if (bus_src !== 2'd0) $display("FAIL single_src_hold got=%0d exp=0", bus_src); else n_pass++;
  endtask

  task automatic test_fairness;
    int e;
    do_reset;
    for (int i = 0; i < N; i++) set_req(i, 4'd0, DW'(32'hC0 + i));
    req_valid = 4'hF; bus_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = k % N; #1;
      n_tot++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL fair_gap%0d got=%b/%b exp=0000/0", k, grant, busy); else n_pass++;
      cyc;
      n_tot++; if (grant !== 4'(1 << e) || bus_src !== 2'(e)) $display("FAIL fair_grant%0d got=%b/%0d exp=%b/%0d", k, grant, bus_src, 4'(1 << e), e); else n_pass++;
      n_tot++; if (bus_last !== 1'b1 || bus_data !== DW'(32'hC0 + e)) $display("FAIL fair_beat%0d got=%b/%h exp=1/%h", k, bus_last, bus_data, 32'hC0 + e); else n_pass++;
      cyc;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int beats = 0;
    do_reset;
    set_req(2, 4'd2, 32'hB0); req_valid = 4'b0100; bus_ready = 1'b0;
    cyc;
    for (int c = 0; c < 5; c++) begin
      bus_ready = pat[c];
      req_data[2*DW +: DW] = DW'(32'hB0 + beats); #1;
      n_tot++; if (req_ready !== (pat[c] ? 4'b0100 : 4'b0000) || busy !== 1'b1)
        $display("FAIL bp_ready%0d got=%b/%b exp=%b/1", c, req_ready, busy, (pat[c] ? 4'b0100 : 4'b0000)); else n_pass++;
      n_tot++; if (bus_data !== DW'(32'hB0 + beats) || bus_last !== (beats == 2))
        $display("FAIL bp_data%0d got=%h/%b exp=%h/%b", c, bus_data, bus_last, 32'hB0 + beats, (beats == 2)); else n_pass++;
      if (pat[c]) beats++;
      cyc;
    end
    n_tot++; if (busy !== 1'b0 || grant !== 4'b0) $display("FAIL bp_done got=%b/%b exp=0/0000", busy, grant); else n_pass++;
    req_valid = '0;
  endtask

  // Starts from ptr left at 2 by the previous test; reset must restore 3.
  task automatic test_mid_reset;
    set_req(0, 4'd7, 32'hE0); req_valid = 4'b0001; bus_ready = 1'b1;
    cyc; cyc;
    rst = 1'b1; #1;
    n_tot++; if (bus_valid !== 1'b1 || grant !== 4'b0001) $display("FAIL mr_inburst got=%b/%b exp=1/0001", bus_valid, grant); else n_pass++;
    cyc;
    rst = 1'b0; req_valid = 4'hF; #1;
    n_tot++; if (grant !== 4'b0 || busy !== 1'b0) $display("FAIL mr_cleared got=%b/%b exp=0000/0", grant, busy); else n_pass++;
    cyc;
    n_tot++; if (grant !== 4'b0001 || bus_src !== 2'd0) $display("FAIL mr_regrant got=%b/%0d exp=0001/0", grant, bus_src); else n_pass++;
  endtask

  task automatic test_stall_len;
    do_reset;
    set_req(1, 4'd1, 32'hA5); req_valid = 4'b0010; bus_ready = 1'b1;
    cyc;
    req_len[1*LW +: LW] = 4'd0; #1;
    n_tot++; if (bus_valid !== 1'b1 || bus_last !== 1'b0) $display("FAIL sl_first got=%b/%b exp=1/0", bus_valid, bus_last); else n_pass++;
    cyc;
    req_valid = 4'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tot++; if (bus_valid !== 1'b0 || busy !== 1'b1 || bus_last !== 1'b0)
        $display("FAIL sl_stall%0d got=%b/%b/%b exp=0/1/0", c, bus_valid, busy, bus_last); else n_pass++;
      cyc;
    end
    req_valid = 4'b0010; #1;
    n_tot++; if (bus_valid !== 1'b1 || bus_last !== 1'b1) $display("FAIL sl_last got=%b/%b exp=1/1", bus_valid, bus_last); else n_pass++;
    cyc;
    n_tot++; if (busy !== 1'b0) $display("FAIL sl_done got=%b exp=0", busy); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_max_len;
    do_reset;
    set_req(3, 4'd15, 32'hD00); req_valid = 4'b1000; bus_ready = 1'b1;
    cyc;
    for (int b = 0; b < 16; b++) begin
      req_data[3*DW +: DW] = DW'(32'hD00 + b); #1;
      n_tot++; if (bus_last !== (b == 15) || bus_data !== DW'(32'hD00 + b) || busy !== 1'b1)
        $display("FAIL max_beat%0d got=%b/%h/%b exp=%b/%h/1", b, bus_last, bus_data, busy, (b == 15), 32'hD00 + b); else n_pass++;
      cyc;
    end
    n_tot++; if (busy !== 1'b0 || grant !== 4'b0) $display("FAIL max_done got=%b/%b exp=0/0000", busy, grant); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_timeout;
    do_reset;
    set_req(1, 4'd3, 32'hF0); req_valid = 4'b0010; bus_ready = 1'b0;
    cyc;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) begin
      #1;
      n_tot++; if (timeout_err !== 1'b0 || grant !== 4'b0010) $display("FAIL to_wait%0d got=%b/%b exp=0/0010", c, timeout_err, grant); else n_pass++;
      cyc;
    end
    n_tot++; if (timeout_err !== 1'b1 || grant !== 4'b0 || busy !== 1'b0) $display("FAIL to_pulse got=%b/%b/%b exp=1/0000/0", timeout_err, grant, busy); else n_pass++;
    req_valid = 4'hF;
    cyc;
    n_tot++; if (timeout_err !== 1'b0 || grant !== 4'b0100) $display("FAIL to_next got=%b/%b exp=0/0100", timeout_err, grant); else n_pass++;
`else
    for (int c = 0; c < 20; c++) begin
      #1;
      n_tot++; if (timeout_err !== 1'b0 || grant !== 4'b0010 || busy !== 1'b1)
        $display("FAIL to_hold%0d got=%b/%b/%b exp=0/0010/1", c, timeout_err, grant, busy); else n_pass++;
      cyc;
    end
`endif
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_backpressure;
    test_mid_reset;
    test_stall_len;
    test_max_len;
    test_timeout;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
